// File: rtl/fifo_drain_stage.sv
// fifo_drain_stage: read-side consumer of the frontend command FIFO.
// Pops a show-ahead FIFO and presents each entry on a registered
// valid/ready stream through a 2-entry skid buffer. The FIFO pop
// request depends only on local occupancy, never on i_ready, so the
// downstream ready path stays off the FIFO rd_en path. Completed
// transfers are counted in a wrapping debug counter.
//
// Optional feature: define DRAIN_FLUSH_EN to add the i_flush input.
// It discards buffered entries without clearing the transfer counter.
module fifo_drain_stage #(
  parameter int DATA_WIDTH     = 4,
  parameter int XFER_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_WIDTH-1:0]     i_fifo_data,
  input  logic                      i_fifo_empty,
`ifdef DRAIN_FLUSH_EN
  input  logic                      i_flush,
`endif
  output logic                      o_fifo_rd_en,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [1:0]                o_occupancy,
  output logic [XFER_CNT_WIDTH-1:0] o_xfer_cnt
);

  // Occupancy of the skid buffer. Encoding 3 is illegal.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e                      occ_q, occ_d;
  logic [DATA_WIDTH-1:0]     slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0]     slot1_q, slot1_d;
  logic                      valid_q, valid_d;
  logic [XFER_CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

  logic flush;
  logic pop_in;
  logic pop_out;

`ifdef DRAIN_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Pop whenever the FIFO has data and the buffer has room. Reset is
  // included so that no pop is requested while the stage is held in reset.
  assign pop_in  = i_rst_n && !i_fifo_empty && (occ_q != OCC_FULL) && !flush;
  assign pop_out = valid_q && i_ready;

  assign o_fifo_rd_en = pop_in;
  assign o_valid      = valid_q;
  assign o_data       = slot0_q;
  assign o_occupancy  = occ_q;
  assign o_xfer_cnt   = xfer_cnt_q;

  // Next-state logic for the skid buffer and the transfer counter.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    occ_d      = occ_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    xfer_cnt_d = xfer_cnt_q;

    if (pop_out) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end

    case (occ_q)
      OCC_EMPTY: begin
        if (pop_in) begin
          slot0_d = i_fifo_data;
          occ_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (pop_in && !pop_out) begin
          slot1_d = i_fifo_data;
          occ_d   = OCC_FULL;
        end else if (pop_in && pop_out) begin
          // Streaming: the head leaves and the new entry replaces it.
          slot0_d = i_fifo_data;
        end else if (pop_out) begin
          occ_d   = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // No pop is requested in FULL, so only a drain can happen.
        if (pop_out) begin
          slot0_d = slot1_q;
          occ_d   = OCC_ONE;
        end
      end
      default: begin
        // Illegal encoding: recover to a clean empty buffer.
        occ_d = OCC_EMPTY;
      end
    endcase

    if (flush) begin
      occ_d = OCC_EMPTY;
    end

    // o_valid is registered from the next occupancy.
    valid_d = (occ_d != OCC_EMPTY);
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the data slots are reset too, because o_data is observable
      // straight after reset and must read as zero.
      occ_q      <= OCC_EMPTY;
      slot0_q    <= '0;
      slot1_q    <= '0;
      valid_q    <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the
      // pre-edge values, independent of statement order.
      occ_q      <= occ_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      valid_q    <= valid_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Testbench for fifo_drain_stage. A queue models the upstream show-ahead
// FIFO; every pop the DUT requests pushes that entry onto a scoreboard,
// and every accepted output pops and compares against it.
module tb_fifo_drain_stage;

  localparam int DW = 4;
  localparam int CW = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_rd_en;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_occupancy;
  logic [CW-1:0] o_xfer_cnt;
`ifdef DRAIN_FLUSH_EN
  logic          i_flush;
`endif

  fifo_drain_stage #(.DATA_WIDTH(DW), .XFER_CNT_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
`ifdef DRAIN_FLUSH_EN
    .i_flush      (i_flush),
`endif
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_occupancy  (o_occupancy),
    .o_xfer_cnt   (o_xfer_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] cnt_model;

  int            cyc;
  int            rd_cnt, rd_run, rd_run_max, first_rd;
  int            out_cnt, first_out, last_out;
  logic          prev_rd, prev_hold;
  logic [DW-1:0] prev_data;

  task automatic clear_stats();
    rd_cnt = 0; rd_run = 0; rd_run_max = 0; first_rd = -1;
    out_cnt = 0; first_out = -1; last_out = -1;
    prev_rd = 1'b0; prev_hold = 1'b0;
  endtask

  // Present the head of the model FIFO (junk data when empty).
  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() == 0) ? DW'($urandom) : fifo_q[0];
  endtask

  // One clock: sample at the falling edge, update the models, then
  // refresh the FIFO inputs just after the rising edge.
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge i_clk);
    if (i_rst_n) begin
      total++;
      if (o_xfer_cnt !== cnt_model) begin
        bad++;
        $display("FAIL xfer_cnt cyc=%0d got=%0d exp=%0d", cyc, o_xfer_cnt, cnt_model);
      end
      if (prev_rd) begin
        total++;
        if (o_valid !== 1'b1) begin
          bad++;
          $display("FAIL latency cyc=%0d o_valid=%b exp=1", cyc, o_valid);
        end
      end
      if (prev_hold) begin
        total++;
        if (o_valid !== 1'b1 || o_data !== prev_data) begin
          bad++;
          $display("FAIL stability cyc=%0d o_valid=%b o_data=%h exp_data=%h",
                   cyc, o_valid, o_data, prev_data);
        end
      end
      if (o_valid && i_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_output cyc=%0d o_data=%h exp=none", cyc, o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            bad++;
            $display("FAIL order cyc=%0d o_data=%h exp=%h", cyc, o_data, e);
          end
        end
        cnt_model++;
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (o_fifo_rd_en) begin
        total++;
        if (fifo_q.size() == 0 || i_fifo_empty) begin
          bad++;
          $display("FAIL rd_en_when_empty cyc=%0d rd_en=1 exp=0", cyc);
        end else begin
          exp_q.push_back(fifo_q.pop_front());
        end
        rd_cnt++;
        rd_run++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
        if (first_rd < 0) first_rd = cyc;
      end else begin
        rd_run = 0;
      end
      prev_rd   = o_fifo_rd_en;
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
`ifdef DRAIN_FLUSH_EN
      if (i_flush) begin
        exp_q.delete();
        prev_rd   = 1'b0;
        prev_hold = 1'b0;
      end
`endif
    end else begin
      prev_rd   = 1'b0;
      prev_hold = 1'b0;
    end
    cyc++;
    @(posedge i_clk);
    #1;
    drive_fifo();
  endtask

  // Run until everything pushed has come out, within a cycle budget.
  task automatic run_drain(input int max_cyc, input bit toggle);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      cycle();
      if (toggle) i_ready = ~i_ready;
      n++;
    end
    total++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout fifo_left=%0d exp_left=%0d exp=0/0",
               fifo_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_ready = 1'b1;
`ifdef DRAIN_FLUSH_EN
    i_flush = 1'b0;
`endif
    cnt_model = '0;
    cyc = 0;
    clear_stats();
    drive_fifo();
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if ({o_fifo_rd_en, o_valid, o_occupancy, o_data, o_xfer_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_values rd_en=%b valid=%b occ=%0d data=%h cnt=%0d exp=all0",
               o_fifo_rd_en, o_valid, o_occupancy, o_data, o_xfer_cnt);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++;
      if ({o_fifo_rd_en, o_valid, o_occupancy} !== '0 || o_xfer_cnt !== '0) begin
        bad++;
        $display("FAIL idle_empty i=%0d rd_en=%b valid=%b occ=%0d cnt=%0d exp=all0",
                 i, o_fifo_rd_en, o_valid, o_occupancy, o_xfer_cnt);
      end
    end
  endtask

  task automatic test_stream();
    clear_stats();
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
    drive_fifo();
    run_drain(40, 1'b0);
    total++;
    if (rd_cnt != 8 || rd_run_max != 8) begin
      bad++;
      $display("FAIL stream_rd_en pops=%0d run=%0d exp=8/8", rd_cnt, rd_run_max);
    end
    total++;
    if (out_cnt != 8 || last_out - first_out != 7 || first_out != first_rd + 1) begin
      bad++;
      $display("FAIL stream_out cnt=%0d span=%0d lat=%0d exp=8/7/1",
               out_cnt, last_out - first_out, first_out - first_rd);
    end
    total++;
    if (o_xfer_cnt !== CW'(8) || o_valid !== 1'b0 || o_occupancy !== 2'd0) begin
      bad++;
      $display("FAIL stream_end cnt=%0d valid=%b occ=%0d exp=8/0/0",
               o_xfer_cnt, o_valid, o_occupancy);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    i_ready = 1'b0;
    fifo_q.push_back(4'hA);
    fifo_q.push_back(4'hB);
    fifo_q.push_back(4'hC);
    drive_fifo();
    repeat (5) cycle();
    total++;
    if (rd_cnt != 2 || o_occupancy !== 2'd2 || o_fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL bp_full pops=%0d occ=%0d rd_en=%b exp=2/2/0",
               rd_cnt, o_occupancy, o_fifo_rd_en);
    end
    total++;
    if (o_valid !== 1'b1 || o_data !== 4'hA) begin
      bad++;
      $display("FAIL bp_head valid=%b data=%h exp=1/a", o_valid, o_data);
    end
    i_ready = 1'b1;
    run_drain(20, 1'b0);
    total++;
    if (out_cnt != 3 || o_xfer_cnt !== CW'(11)) begin
      bad++;
      $display("FAIL bp_drain outs=%0d cnt=%0d exp=3/11", out_cnt, o_xfer_cnt);
    end
  endtask

  task automatic test_toggle();
    logic [CW-1:0] base;
    clear_stats();
    base = o_xfer_cnt;
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
    drive_fifo();
    run_drain(100, 1'b1);
    total++;
    if (out_cnt != 16 || o_xfer_cnt !== base + CW'(16)) begin
      bad++;
      $display("FAIL toggle outs=%0d cnt=%0d exp=16/%0d", out_cnt, o_xfer_cnt, base + CW'(16));
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    i_ready = 1'b0;
    for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(i));
    drive_fifo();
    repeat (4) cycle();
    total++;
    if (o_occupancy !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset_occ occ=%0d exp=2", o_occupancy);
    end
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_xfer_cnt !== '0 || o_fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL async_reset valid=%b occ=%0d cnt=%0d rd_en=%b exp=0/0/0/0",
               o_valid, o_occupancy, o_xfer_cnt, o_fifo_rd_en);
    end
    cnt_model = '0;
    exp_q.delete();
    fifo_q.delete();
    fifo_q.push_back(4'h5);
    drive_fifo();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    clear_stats();
    run_drain(20, 1'b0);
    total++;
    if (out_cnt != 1 || first_out != first_rd + 1 || o_xfer_cnt !== CW'(1)) begin
      bad++;
      $display("FAIL after_reset outs=%0d lat=%0d cnt=%0d exp=1/1/1",
               out_cnt, first_out - first_rd, o_xfer_cnt);
    end
  endtask

`ifdef DRAIN_FLUSH_EN
  task automatic test_flush();
    logic [CW-1:0] base;
    clear_stats();
    i_ready = 1'b0;
    fifo_q.push_back(4'h7);
    fifo_q.push_back(4'h8);
    fifo_q.push_back(4'h9);
    drive_fifo();
    cycle();
    // One entry held, FIFO not empty: flush must still block the pop.
    i_flush = 1'b1;
    #1;
    total++;
    if (o_fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_blocks_pop rd_en=%b exp=0", o_fifo_rd_en);
    end
    cycle();
    i_flush = 1'b0;
    repeat (3) cycle();
    total++;
    if (o_occupancy !== 2'd2) begin
      bad++;
      $display("FAIL pre_flush_occ occ=%0d exp=2", o_occupancy);
    end
    base = o_xfer_cnt;
    i_flush = 1'b1;
    #1;
    total++;
    if (o_fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_rd_en rd_en=%b exp=0", o_fifo_rd_en);
    end
    cycle();
    i_flush = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_xfer_cnt !== base) begin
      bad++;
      $display("FAIL flush_result valid=%b occ=%0d cnt=%0d exp=0/0/%0d",
               o_valid, o_occupancy, o_xfer_cnt, base);
    end
    i_ready = 1'b1;
    run_drain(20, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef DRAIN_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait ever goes astray.
  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_drain_stage.md
Name: fifo_drain_stage

Overview:
- Read-side consumer of the frontend command FIFO.
- Pops entries from a show-ahead synchronous FIFO (head data visible while not empty; rd_en pops on the clock edge).
- Presents the entries downstream on a registered valid/ready stream through a 2-entry skid buffer.
- Decouples the downstream ready path from the FIFO rd_en path, sustains 1 transfer/cycle, and counts completed transfers for debug.

Parameters:
- DATA_WIDTH, 4, width of FIFO entry and output payload.
- XFER_CNT_WIDTH, 16, width of the wrapping transfer counter.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_fifo_data  input  DATA_WIDTH  FIFO head entry, valid when i_fifo_empty=0
- i_fifo_empty  input  1  FIFO empty flag
- o_fifo_rd_en  output  1  pop request to FIFO (combinational)
- o_valid  output  1  output entry valid
- i_ready  input  1  downstream accepts when o_valid=1
- o_data  output  DATA_WIDTH  output entry (buffer head)
- o_occupancy  output  2  entries held in skid buffer (0..2)
- o_xfer_cnt  output  XFER_CNT_WIDTH  completed transfers (o_valid&&i_ready), wraps

Behaviour:
- One clock, i_clk; reset is asynchronous, active-low, on i_rst_n.
- Reset values: occupancy=0, o_valid=0, o_data=0, both buffer slots=0, o_xfer_cnt=0.
- o_fifo_rd_en is forced 0 while i_rst_n=0.
- Storage is 2 registers: slot0 (head, drives o_data) and slot1 (skid).
- State = occupancy:
  - EMPTY(0)
  - ONE(1)
  - FULL(2)
- pop_in = o_fifo_rd_en = i_rst_n && !i_fifo_empty && (occupancy != 2).
  - No combinational path from i_ready to o_fifo_rd_en.
- pop_out = o_valid && i_ready; o_valid = (occupancy != 0), registered.
- i_fifo_data is captured on the same edge where o_fifo_rd_en=1 (show-ahead FIFO).
- Transitions:
  - EMPTY: pop_in -> slot0<=data, ONE.
  - ONE, pop_in && !pop_out -> slot1<=data, FULL.
  - ONE, pop_in && pop_out -> slot0<=data, stay ONE (streaming, 1 entry/cycle).
  - ONE, !pop_in && pop_out -> EMPTY.
  - ONE, neither -> hold.
  - FULL, pop_out -> slot0<=slot1, ONE (pop_in is 0 in FULL).
  - FULL, !pop_out -> hold, o_fifo_rd_en=0.
- Latency: entry popped at edge N is on o_valid/o_data after edge N (visible in cycle N+1).
- Ordering: strict FIFO order; no entry dropped or duplicated.
- Stability: while o_valid=1 && i_ready=0, o_data and o_valid hold.
- i_ready while o_valid=0 is ignored; it does not count.
- o_xfer_cnt increments by 1 per pop_out and wraps from 2^XFER_CNT_WIDTH-1 to 0.
- i_fifo_empty=1 blocks pops regardless of state; i_fifo_data is ignored when empty.
- Reset mid-operation: buffered entries are discarded and counters clear immediately (asynchronous); the first pop after release follows the EMPTY rules.
- Illegal occupancy value 3 is unreachable; if it occurs, the next state is EMPTY.

Optional Feature:
- Macro: DRAIN_FLUSH_EN.
- Defined:
  - Adds port i_flush (input, 1).
  - i_flush=1 forces o_fifo_rd_en=0 that cycle and sets occupancy<=0 at the next edge, so o_valid=0 from the next cycle.
  - A pop_out in the flush cycle still counts in o_xfer_cnt.
  - o_xfer_cnt is not cleared.
- Undefined: no i_flush port; behaviour as above.

Test Plan:
- Reset, FIFO empty, i_ready=1, 10 cycles -> o_fifo_rd_en=0, o_valid=0, o_occupancy=0, o_xfer_cnt=0.
- FIFO holds 0x1..0x8, i_ready=1 constant -> o_fifo_rd_en high 8 consecutive cycles; o_data 0x1..0x8 on 8 consecutive cycles starting 1 cycle after first pop; o_xfer_cnt=8.
- FIFO holds 0xA,0xB,0xC, i_ready=0 -> exactly 2 pops, o_occupancy=2, o_fifo_rd_en=0, o_data=0xA stable. Raise i_ready -> 0xA, 0xB, 0xC in order, no loss.
- i_ready toggling 1,0,1,0 with continuous FIFO data 0x0..0xF -> output sequence exactly 0x0..0xF, o_data constant during every ready-low cycle, o_xfer_cnt=16.
- Assert i_rst_n=0 mid-stream with o_occupancy=2 -> immediately o_valid=0, o_occupancy=0, o_xfer_cnt=0, o_fifo_rd_en=0. After release with FIFO holding 0x5 -> 0x5 appears 1 cycle after pop.
- With DRAIN_FLUSH_EN, o_occupancy=2, pulse i_flush 1 cycle with i_ready=0 -> next cycle o_valid=0, o_occupancy=0, o_fifo_rd_en=0 during the flush cycle, o_xfer_cnt unchanged.
